// File: rtl/coh_snoop_responder.sv
// coh_snoop_responder: queues hub snoops, looks up / downgrades the local cache, answers each snoop in order.
module coh_snoop_responder #(
    parameter int DEPTH    = 4,
    parameter int LINE_OFF = 6
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [7:0]  snp_rqst,
    input  logic [7:0]  snp_trsc,
    input  logic [63:0] snp_addr,
    output logic [7:0]  snp_resp,
    output logic [7:0]  snp_mesi,
    output logic        lk_req,
    output logic [63:0] lk_addr,
    input  logic        lk_ack,
    input  logic        lk_hit,
    input  logic        lk_dirty,
    output logic        act_req,
    output logic [1:0]  act_op,
    input  logic        act_ack,
    output logic        busy,
    output logic        ovf
);
    localparam int AW = $clog2(DEPTH);
    typedef enum logic [1:0] {IDLE, LOOK, ACT, RESP} state_t;
    state_t state_q, state_d;
    logic [79:0] mem_q [DEPTH];
    logic [79:0] head;
    logic [AW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [AW:0] cnt_q, cnt_d;
    logic [7:0] id_q, id_d, trsc_q, trsc_d, resp_q, resp_d, mesi_q, mesi_d;
    logic [63:0] addr_q, addr_d;
    logic [1:0] op_q, op_d;
    logic hit_q, hit_d, ovf_q, ovf_d;
    logic push, pop, full, accept;
    logic unused_dirty;

    always_comb begin
        push = snp_rqst != 8'd0;
        pop = state_q == RESP;
        full = cnt_q == (AW+1)'(DEPTH);
        accept = push && (!full || pop);
        head = mem_q[rd_ptr_q];
        wr_ptr_d = wr_ptr_q + AW'(accept);
        rd_ptr_d = rd_ptr_q + AW'(pop);
        cnt_d = cnt_q + (AW+1)'(accept) - (AW+1)'(pop);
        ovf_d = ovf_q || (push && full && !pop);
        state_d = state_q;
        id_d = id_q;
        trsc_d = trsc_q;
        addr_d = addr_q;
        hit_d = hit_q;
        op_d = op_q;
        resp_d = 8'd0;
        mesi_d = 8'd0;
        unused_dirty = lk_dirty;
        case (state_q)
            IDLE: if (cnt_q != '0) begin
                id_d = head[79:72];
                trsc_d = head[71:64];
                addr_d = head[63:0];
                hit_d = 1'b0;
                state_d = (head[71:64] == 8'h01 || head[71:64] == 8'h02) ? LOOK : RESP;
            end
            LOOK: if (lk_ack) begin
                hit_d = lk_hit;
                op_d = trsc_q == 8'h01 ? 2'd1 : 2'd2;
                state_d = lk_hit ? ACT : RESP;
            end
            ACT: state_d = act_ack ? RESP : ACT;
            default: begin
                resp_d = id_q;
                mesi_d = {7'd0, trsc_q == 8'h01 && hit_q};
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk)
        if (accept) mem_q[wr_ptr_q] <= {snp_rqst, snp_trsc, snp_addr};

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q <= '0;
            ovf_q <= 1'b0;
            id_q <= '0;
            trsc_q <= '0;
            addr_q <= '0;
            hit_q <= 1'b0;
            op_q <= '0;
            resp_q <= '0;
            mesi_q <= '0;
        end else begin
            state_q <= state_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            cnt_q <= cnt_d;
            ovf_q <= ovf_d;
            id_q <= id_d;
            trsc_q <= trsc_d;
            addr_q <= addr_d;
            hit_q <= hit_d;
            op_q <= op_d;
            resp_q <= resp_d;
            mesi_q <= mesi_d;
        end
    end

    assign lk_req = state_q == LOOK;
    assign lk_addr = lk_req ? {addr_q[63:LINE_OFF], {LINE_OFF{1'b0}}} : 64'd0;
    assign act_req = state_q == ACT;
    assign act_op = act_req ? op_q : 2'd0;
    assign snp_resp = resp_q;
    assign snp_mesi = mesi_q;
    assign busy = cnt_q != '0 || state_q != IDLE;
    assign ovf = ovf_q;
endmodule
